// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter, cache controllers and memory model.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } arb_state_t;

  localparam int DEFAULT_MEM_LATENCY = 6;
  localparam int LINE_WORDS          = 4;

  // Wide enough for the largest legal latency load value (15 - 1).
  localparam int TIMER_W = 4;

  function automatic logic [TIMER_W-1:0] latencyLoad(input int latency);
    return TIMER_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// Load/decrement down-counter with terminal-count flag; times one memory access.
module mem_latency_timer
  import mem_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Holds at zero rather than wrapping so a late decrement is harmless.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single fixed-latency memory port between the I-cache and D-cache miss paths
// and drives the pipeline stall vector.
//
// state | meaning
// IDLE  | port free, requests sampled every cycle
// I_ACC | I-cache line fill in flight
// D_ACC | D-cache line fill or write-through in flight
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY  // legal 2..15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic              grant_d,
  output logic [1:0]        cacheStall,
  output logic [15:0]       num_mem_access
);

  arb_state_t state;
  logic       lastD;
  logic       anyReq;
  logic       pickD;
  logic       inAcc;
  logic       timerLoad;
  logic       timerZero;

  assign anyReq    = i_req || d_req;
  // On a tie the side not served last wins; a lone request always wins.
  assign pickD     = d_req && (!i_req || !lastD);
  assign inAcc     = (state == I_ACC) || (state == D_ACC);
  assign timerLoad = (state == IDLE) && anyReq;

  mem_latency_timer #(
    .W(TIMER_W)
  ) u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (timerLoad),
    .loadValue(latencyLoad(MEM_LATENCY)),
    .dec      (inAcc),
    .zero     (timerZero)
  );

  assign i_done = (state == I_ACC) && timerZero;
  assign d_done = (state == D_ACC) && timerZero;

  // Both bits fall in the done cycle so the pipeline advances on that edge.
  assign cacheStall[1] = d_req && !d_done;
  assign cacheStall[0] = i_req && !i_done && !cacheStall[1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      lastD          <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      grant_d        <= 1'b0;
      num_mem_access <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            state       <= pickD ? D_ACC : I_ACC;
            mem_address <= pickD ? d_addr : i_addr;
            mem_read    <= !(pickD && d_we);
            mem_write   <= pickD && d_we;
            grant_d     <= pickD;
            lastD       <= pickD;
          end
        end
        I_ACC, D_ACC: begin
          if (timerZero) begin
            state          <= IDLE;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            grant_d        <= 1'b0;
            num_mem_access <= num_mem_access + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, hand sequences, randomized model compare.
module tb_mem_port_arbiter;

  localparam int LAT = 6;

  logic        Clk;
  logic        Reset;
  logic        iReq;
  logic [15:0] iAddr;
  logic        iDone;
  logic        dReq;
  logic        dWe;
  logic [15:0] dAddr;
  logic        dDone;
  logic        memRead;
  logic        memWrite;
  logic [15:0] memAddress;
  logic        grantD;
  logic [1:0]  cacheStall;
  logic [15:0] numMemAccess;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W     (16),
    .MEM_LATENCY(LAT)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .i_req         (iReq),
    .i_addr        (iAddr),
    .i_done        (iDone),
    .d_req         (dReq),
    .d_we          (dWe),
    .d_addr        (dAddr),
    .d_done        (dDone),
    .mem_read      (memRead),
    .mem_write     (memWrite),
    .mem_address   (memAddress),
    .grant_d       (grantD),
    .cacheStall    (cacheStall),
    .num_mem_access(numMemAccess)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (rd wr gnt idone ddone stall)", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %04h required %04h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  function automatic logic [6:0] obs();
    return {memRead, memWrite, grantD, iDone, dDone, cacheStall};
  endfunction

  typedef struct {
    logic       dReq;
    logic       iReq;
    logic [6:0] exp;   // {read, write, grant_d, i_done, d_done, stall[1:0]}
  } row_t;

  row_t tbl[15];

  function automatic row_t mkRow(input logic d, input logic i, input logic [6:0] e);
    row_t r;
    r.dReq = d;
    r.iReq = i;
    r.exp  = e;
    return r;
  endfunction

  int          mRem;
  logic        mD;
  logic        mWe;
  logic        mLastD;
  logic [15:0] mAddr;
  logic [15:0] mCount;

  initial begin
    logic       eAcc, eRead, eWrite, eGrant, eIDone, eDDone, eS1, eS0;

    // simultaneous I and D after reset: D first, one idle cycle, then I
    tbl[0] = mkRow(1'b1, 1'b1, 7'b000_00_10);
    for (int k = 1; k <= 5; k++) tbl[k] = mkRow(1'b1, 1'b1, 7'b101_00_10);
    tbl[6] = mkRow(1'b1, 1'b1, 7'b101_01_01);
    tbl[7] = mkRow(1'b0, 1'b1, 7'b000_00_01);
    for (int k = 8; k <= 12; k++) tbl[k] = mkRow(1'b0, 1'b1, 7'b100_00_01);
    tbl[13] = mkRow(1'b0, 1'b1, 7'b100_10_00);
    tbl[14] = mkRow(1'b0, 1'b0, 7'b000_00_00);

    Reset = 1'b1;
    iReq  = 1'b0;
    iAddr = 16'h0040;
    dReq  = 1'b0;
    dWe   = 1'b0;
    dAddr = 16'h0100;
    step();
    step();
    Reset = 1'b0;
    sample();
    chk7("reset outputs", obs(), 7'b0);
    chk16("reset address", memAddress, 16'h0000);
    chk16("reset counter", numMemAccess, 16'h0000);

    for (int r = 0; r < 15; r++) begin
      step();
      dReq = tbl[r].dReq;
      iReq = tbl[r].iReq;
      sample();
      chk7($sformatf("tie row %0d", r), obs(), tbl[r].exp);
      if (r == 1) chk16("tie d address", memAddress, 16'h0100);
      if (r == 8) chk16("tie i address", memAddress, 16'h0040);
      if (r == 7) chk16("tie count after d", numMemAccess, 16'd1);
      if (r == 14) chk16("tie count after i", numMemAccess, 16'd2);
    end

    // lone I miss
    iAddr = 16'h0040;
    for (int c = 0; c <= 7; c++) begin
      step();
      iReq = (c <= 6);
      sample();
      chk1($sformatf("loneI read c%0d", c), memRead, (c >= 1 && c <= 6));
      chk1($sformatf("loneI grant c%0d", c), grantD, 1'b0);
      chk1($sformatf("loneI done c%0d", c), iDone, (c == 6));
      chk2($sformatf("loneI stall c%0d", c), cacheStall, (c <= 5) ? 2'b01 : 2'b00);
      if (c >= 1 && c <= 6) chk16("loneI address", memAddress, 16'h0040);
    end
    chk16("loneI count", numMemAccess, 16'd3);

    // lone D write-through; address and we changes mid-access are ignored
    dWe   = 1'b1;
    dAddr = 16'h1234;
    for (int c = 0; c <= 7; c++) begin
      step();
      dReq = (c <= 6);
      if (c == 3) begin
        dAddr = 16'hFFFF;
        dWe   = 1'b0;
      end
      sample();
      chk1($sformatf("loneD write c%0d", c), memWrite, (c >= 1 && c <= 6));
      chk1($sformatf("loneD read c%0d", c), memRead, 1'b0);
      chk1($sformatf("loneD grant c%0d", c), grantD, (c >= 1 && c <= 6));
      chk1($sformatf("loneD done c%0d", c), dDone, (c == 6));
      chk2($sformatf("loneD stall c%0d", c), cacheStall, (c <= 5) ? 2'b10 : 2'b00);
      if (c >= 1 && c <= 6) chk16("loneD address", memAddress, 16'h1234);
    end
    chk16("loneD count", numMemAccess, 16'd4);

    // round-robin: D served last, so I wins the tie, then D wins the next tie
    dWe   = 1'b0;
    dAddr = 16'h0300;
    iAddr = 16'h0500;
    for (int c = 0; c <= 14; c++) begin
      step();
      dReq = (c <= 13);
      iReq = (c <= 13);
      sample();
      if (c == 1) chk1("rr first grant_d", grantD, 1'b0);
      if (c == 1) chk16("rr first address", memAddress, 16'h0500);
      if (c == 3) chk2("rr stall while I served", cacheStall, 2'b10);
      if (c == 6) chk1("rr i_done", iDone, 1'b1);
      if (c == 7) chk1("rr idle gap", memRead, 1'b0);
      if (c == 8) chk1("rr second grant_d", grantD, 1'b1);
      if (c == 13) chk1("rr d_done", dDone, 1'b1);
    end
    chk16("rr count", numMemAccess, 16'd6);

    // reset in cycle 3 of a D fill
    dAddr = 16'h0200;
    for (int c = 0; c <= 8; c++) begin
      step();
      dReq  = (c <= 2);
      Reset = (c == 3);
      sample();
      if (c == 2) chk1("rst read before", memRead, 1'b1);
      if (c >= 3) chk1($sformatf("rst d_done c%0d", c), dDone, 1'b0);
      if (c >= 4) chk7($sformatf("rst outputs c%0d", c), obs(), 7'b0);
      if (c == 4) chk16("rst counter", numMemAccess, 16'd0);
    end

    // requester drops i_req in cycle 2; access still completes
    iAddr = 16'h0080;
    for (int c = 0; c <= 7; c++) begin
      step();
      iReq = (c <= 1);
      sample();
      chk1($sformatf("drop read c%0d", c), memRead, (c >= 1 && c <= 6));
      chk1($sformatf("drop done c%0d", c), iDone, (c == 6));
      chk2($sformatf("drop stall c%0d", c), cacheStall, (c <= 1) ? 2'b01 : 2'b00);
    end
    chk16("drop count", numMemAccess, 16'd1);

    // counter wrap from 0xFFFF
    force dut.num_mem_access = 16'hFFFF;
    #1;
    release dut.num_mem_access;
    chk16("wrap preset", numMemAccess, 16'hFFFF);
    dAddr = 16'h0010;
    for (int c = 0; c <= 7; c++) begin
      step();
      dReq = (c <= 6);
      sample();
      if (c == 6) chk16("wrap before", numMemAccess, 16'hFFFF);
      if (c == 7) chk16("wrap after", numMemAccess, 16'h0000);
    end

    // randomized traffic against the reference model
    step();
    Reset = 1'b1;
    iReq  = 1'b0;
    dReq  = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge Clk);
      if (Reset) begin
        mRem   = 0;
        mD     = 1'b0;
        mWe    = 1'b0;
        mLastD = 1'b0;
        mAddr  = 16'h0000;
        mCount = 16'h0000;
      end else if (mRem > 0) begin
        if (mRem == 1) mCount = mCount + 16'd1;
        mRem = mRem - 1;
      end else if (iReq || dReq) begin
        mD     = dReq && (!iReq || !mLastD);
        mLastD = mD;
        mWe    = mD && dWe;
        mAddr  = mD ? dAddr : iAddr;
        mRem   = LAT;
      end
      #1;
      Reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) iReq = ~iReq;
      if ($urandom_range(0, 3) == 0) dReq = ~dReq;
      dWe   = ($urandom_range(0, 1) == 1);
      iAddr = 16'($urandom());
      dAddr = 16'($urandom());
      sample();
      eAcc   = (mRem > 0);
      eRead  = eAcc && !mWe;
      eWrite = eAcc && mWe;
      eGrant = eAcc && mD;
      eIDone = eAcc && !mD && (mRem == 1);
      eDDone = eAcc && mD && (mRem == 1);
      eS1    = dReq && !eDDone;
      eS0    = iReq && !eIDone && !eS1;
      chk7($sformatf("rand outputs n%0d", n), obs(),
           {eRead, eWrite, eGrant, eIDone, eDDone, eS1, eS0});
      chk16($sformatf("rand count n%0d", n), numMemAccess, mCount);
      if (eAcc) chk16($sformatf("rand address n%0d", n), memAddress, mAddr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
